// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: FSM state encoding, RISC-V
// opcode constants, datapath ALU opcodes, ALU status flag bit positions and
// the funct3-to-ALU-operation mapping used by the decoder.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_SLL  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_SLT  = 5'd8;
  localparam logic [4:0] ALU_SLTU = 5'd9;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  // Opcodes that run through EXECUTE; anything else is HALT or a NOP-illegal.
  function automatic logic is_exec_op(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  // Arithmetic/logic funct3 map shared by R and I-ALU; alt picks SUB/SRA.
  function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_alu_op_decoder.sv
// Combinational decode of opcode/funct3/funct7[5] into the datapath ALU
// opcode and the ALU B-operand select.
module alu_op_decoder
  import ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 5
) (
  input  logic [6:0]          opcode_i,
  input  logic [2:0]          funct3_i,
  input  logic                funct7_5_i,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                alu_src_o
);

  // Immediate forms only honour funct7[5] on the right shift (SRAI vs SRLI).
  always_comb begin
    alu_op_o  = ALU_OP_W'(ALU_ADD);
    alu_src_o = 1'b0;
    case (opcode_i)
      OP_R: alu_op_o = ALU_OP_W'(alu_from_f3(funct3_i, funct7_5_i));
      OP_I: begin
        alu_op_o  = ALU_OP_W'(alu_from_f3(funct3_i, funct7_5_i && (funct3_i == 3'b101)));
        alu_src_o = 1'b1;
      end
      OP_LOAD, OP_STORE: alu_src_o = 1'b1;
      OP_BRANCH: alu_op_o = ALU_OP_W'(ALU_SUB);
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control FSM driving the single-cycle datapath control inputs.
// FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK] -> FETCH, with HALT
// left only through reset. Outputs come from the state and latched ir, except
// the branch PCSrc (live Z flag) and the illegal-opcode NOP retire in DECODE,
// which must look at inst because ir is only being loaded in that cycle.
// Optional build macro CTRL_PERF_COUNTER_EN adds a retired-instruction counter.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 5,
  parameter int STATUS_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         inst,
  input  logic [STATUS_W-1:0] status,
  output logic                RegWrite,
  output logic                PCSrc,
  output logic                ALUSrc,
  output logic [ALU_OP_W-1:0] ALU_operation,
  output logic                write,
  output logic                MemtoReg,
  output logic                pc_en,
  output logic                halted,
  output logic                illegal,
  output logic [31:0]         instr_retired
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;

  logic [6:0] ir_op;
  logic [2:0] ir_f3;
  logic [6:0] in_op;
  logic       in_halt;
  logic       in_exec;

  assign ir_op   = ir_q[6:0];
  assign ir_f3   = ir_q[14:12];
  assign in_op   = inst[6:0];
  assign in_halt = (inst == 32'd0) || (in_op == OP_SYS);
  assign in_exec = is_exec_op(in_op);

  // State, instruction register and sticky illegal flag; reset wins everywhere.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state sequencing; ir captures inst only in DECODE.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        ir_d = inst;
        if (in_halt)      state_d = S_HALT;
        else if (in_exec) state_d = S_EXECUTE;
        else begin
          illegal_d = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_EXECUTE: begin
        case (ir_op)
          OP_LOAD, OP_STORE: state_d = S_MEMORY;
          OP_BRANCH:         state_d = S_FETCH;
          default:           state_d = S_WRITEBACK;
        endcase
      end
      S_MEMORY:    state_d = (ir_op == OP_STORE) ? S_FETCH : S_WRITEBACK;
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end

  // Control outputs; each instruction raises pc_en in exactly its final cycle.
  always_comb begin
    RegWrite = (state_q == S_WRITEBACK);
    write    = (state_q == S_MEMORY) && (ir_op == OP_STORE);
    MemtoReg = !((state_q == S_WRITEBACK) && (ir_op == OP_LOAD));
    halted   = (state_q == S_HALT);
    pc_en    = (state_q == S_WRITEBACK) ||
               ((state_q == S_MEMORY)  && (ir_op == OP_STORE)) ||
               ((state_q == S_EXECUTE) && (ir_op == OP_BRANCH)) ||
               ((state_q == S_DECODE)  && !in_halt && !in_exec);
    PCSrc    = 1'b0;
    if ((state_q == S_EXECUTE) && (ir_op == OP_BRANCH)) begin
      case (ir_f3)
        3'b000:  PCSrc =  status[FLAG_Z];
        3'b001:  PCSrc = ~status[FLAG_Z];
        default: PCSrc = 1'b0;
      endcase
    end
  end

  assign illegal = illegal_q;

  alu_op_decoder #(.ALU_OP_W(ALU_OP_W)) u_dec (
    .opcode_i   (ir_op),
    .funct3_i   (ir_f3),
    .funct7_5_i (ir_q[30]),
    .alu_op_o   (ALU_operation),
    .alu_src_o  (ALUSrc)
  );

`ifdef CTRL_PERF_COUNTER_EN
  logic [31:0] cnt_q;

  // Retired-instruction count, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!reset)     cnt_q <= '0;
    else if (pc_en) cnt_q <= cnt_q + 32'd1;
  end

  assign instr_retired = cnt_q;
`else
  assign instr_retired = '0;
`endif

  // Flags other than Z and ir fields beyond opcode/funct3/funct7[5] are not used.
  logic unused_bits;
  assign unused_bits = ^{status, ir_q[31], ir_q[29:15], ir_q[11:7]};

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer. Each instruction pushes its expected
// per-cycle control vectors into a scoreboard queue; the queue is drained one
// entry per clock, comparing #1 after the rising edge.
module tb_control_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] inst;
  logic [3:0]  status;
  logic        RegWrite, PCSrc, ALUSrc, write, MemtoReg, pc_en, halted, illegal;
  logic [4:0]  ALU_operation;
  logic [31:0] instr_retired;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        rw, pcsrc, wr, m2r, pce, hlt, ill, src;
    logic [4:0]  op;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_ILL = 4, K_HALT = 5;

  // Bench-side tracking of state that carries over between instructions.
  logic        ill_s;
  logic        prev_src;
  logic [4:0]  prev_op;
  logic [31:0] cnt_s;

  control_sequencer #(.ALU_OP_W(5), .STATUS_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .inst          (inst),
    .status        (status),
    .RegWrite      (RegWrite),
    .PCSrc         (PCSrc),
    .ALUSrc        (ALUSrc),
    .ALU_operation (ALU_operation),
    .write         (write),
    .MemtoReg      (MemtoReg),
    .pc_en         (pc_en),
    .halted        (halted),
    .illegal       (illegal),
    .instr_retired (instr_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e);
    chk({tag, ".RegWrite"}, 32'(RegWrite), 32'(e.rw));
    chk({tag, ".PCSrc"},    32'(PCSrc),    32'(e.pcsrc));
    chk({tag, ".write"},    32'(write),    32'(e.wr));
    chk({tag, ".MemtoReg"}, 32'(MemtoReg), 32'(e.m2r));
    chk({tag, ".pc_en"},    32'(pc_en),    32'(e.pce));
    chk({tag, ".halted"},   32'(halted),   32'(e.hlt));
    chk({tag, ".illegal"},  32'(illegal),  32'(e.ill));
    chk({tag, ".ALUSrc"},   32'(ALUSrc),   32'(e.src));
    chk({tag, ".ALUop"},    32'(ALU_operation), 32'(e.op));
    chk({tag, ".retired"},  instr_retired, e.cnt);
  endtask

  task automatic reset_state_check(input string tag);
    exp_t e;
    e = '0;
    e.m2r = 1'b1;
    cmp(tag, e);
  endtask

  // Push expectations for one instruction, then drain them cycle by cycle.
  // abort_at>0 asserts reset before the edge that follows that cycle.
  task automatic run(input string tag, input logic [31:0] ins, input logic [3:0] st,
                     input int kind, input logic taken, input logic [4:0] op,
                     input logic src, input int abort_at);
    int   len;
    exp_t e;
    inst   = ins;
    status = st;
    case (kind)
      K_LOAD:  len = 5;
      K_BR:    len = 3;
      K_ILL:   len = 2;
      K_HALT:  len = 22;
      default: len = 4;
    endcase
    for (int c = 1; c <= len; c++) begin
      e       = '0;
      e.m2r   = 1'b1;
      e.ill   = ill_s;
      e.cnt   = cnt_s;
      e.src   = (c < 3 || kind >= K_ILL) ? prev_src : src;
      e.op    = (c < 3 || kind >= K_ILL) ? prev_op  : op;
      if (kind == K_HALT && c >= 3) e.hlt = 1'b1;
      if (c == len && kind != K_HALT) begin
        e.pce = 1'b1;
        case (kind)
          K_ALU:   e.rw = 1'b1;
          K_LOAD:  begin e.rw = 1'b1; e.m2r = 1'b0; end
          K_STORE: e.wr = 1'b1;
          K_BR:    e.pcsrc = taken;
          default: ;
        endcase
      end
      q.push_back(e);
`ifdef CTRL_PERF_COUNTER_EN
      if (e.pce) cnt_s++;
`endif
    end
    if (kind == K_ILL) ill_s = 1'b1;
    if (kind >= K_ILL) begin
      prev_src = 1'b0;
      prev_op  = 5'd0;
    end else begin
      prev_src = src;
      prev_op  = op;
    end
    for (int i = 1; q.size() > 0; i++) begin
      e = q.pop_front();
      cmp($sformatf("%s.c%0d", tag, i), e);
      if (abort_at != 0 && i == abort_at) begin
        q.delete();
        reset = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic after_reset();
    ill_s    = 1'b0;
    prev_src = 1'b0;
    prev_op  = 5'd0;
    cnt_s    = 32'd0;
  endtask

  initial begin
    after_reset();
    reset  = 1'b0;
    inst   = 32'd0;
    status = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    reset_state_check("reset");
    reset = 1'b1;
    inst  = 32'h002081B3;

    run("add",   32'h002081B3, 4'b0000, K_ALU,   1'b0, 5'd0, 1'b0, 0);
    run("lw",    32'h0080A283, 4'b0000, K_LOAD,  1'b0, 5'd0, 1'b1, 0);
    run("sw",    32'h0020A423, 4'b0000, K_STORE, 1'b0, 5'd0, 1'b1, 0);
    run("beq_t", 32'h00208463, 4'b0001, K_BR,    1'b1, 5'd1, 1'b0, 0);
    run("beq_n", 32'h00208463, 4'b0000, K_BR,    1'b0, 5'd1, 1'b0, 0);
    run("bne_t", 32'h00209463, 4'b0000, K_BR,    1'b1, 5'd1, 1'b0, 0);
    run("bne_n", 32'h00209463, 4'b1111, K_BR,    1'b0, 5'd1, 1'b0, 0);
    run("addi",  32'h00800093, 4'b0000, K_ALU,   1'b0, 5'd0, 1'b1, 0);
    run("sub",   32'h402081B3, 4'b0000, K_ALU,   1'b0, 5'd1, 1'b0, 0);
    run("srai",  32'h4030D093, 4'b0000, K_ALU,   1'b0, 5'd7, 1'b1, 0);
    run("sltu",  32'h0020B1B3, 4'b0000, K_ALU,   1'b0, 5'd9, 1'b0, 0);
    run("ill",   32'h0000007F, 4'b0000, K_ILL,   1'b0, 5'd0, 1'b0, 0);
    run("and",   32'h0020F1B3, 4'b0000, K_ALU,   1'b0, 5'd2, 1'b0, 0);

    // Reset in MEMORY of a load: next cycle is FETCH with illegal/counter cleared.
    run("lw_rst", 32'h0080A283, 4'b0000, K_LOAD, 1'b0, 5'd0, 1'b1, 4);
    after_reset();
    reset_state_check("midrst");
    reset = 1'b1;

    run("ecall", 32'h00000073, 4'b0000, K_HALT, 1'b0, 5'd0, 1'b0, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    after_reset();
    reset_state_check("halt_rst");
    reset = 1'b1;

    run("zero",  32'h00000000, 4'b0000, K_HALT, 1'b0, 5'd0, 1'b0, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    after_reset();
    reset_state_check("zero_rst");
    reset = 1'b1;
    run("add2",  32'h002081B3, 4'b0000, K_ALU,  1'b0, 5'd0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
